// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_t   per-channel debounce state (2-bit)
//   ms_to_cycles  converts a millisecond interval to clock cycles at a given clock rate
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } btn_state_t;

    // Divide first so large clock rates do not overflow 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and window counter.
// Optional long-press counter when BTN_LONG_PRESS_EN is defined.
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   btn_n       raw pin, active-low, asynchronous to clk
//   level       debounced state, 1 = pressed
//   press       1-cycle pulse on accepted press
//   rel         1-cycle pulse on accepted release
//   long_press  1-cycle pulse LONG_CYC cycles after press (BTN_LONG_PRESS_EN only)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned D        = 4
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYC = 10
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned CW = $clog2(D + 1);

    logic       s0_q, s1_q;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Released is the idle level of an active-low pin.
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s0_q    <= btn_n;
            s1_q    <= s0_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // A bounce back to the settled level always wins over the window
    // completing, so a transition needs D consecutive opposite samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!s1_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (s1_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(D - 1)) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (s1_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            REL_WAIT: begin
                if (!s1_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(D - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == HELD) || (state_q == REL_WAIT);
    assign press = press_q;
    assign rel   = rel_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned LW = $clog2(LONG_CYC + 1);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;
    logic          level_d;

    assign level_d = (state_d == HELD) || (state_d == REL_WAIT);

    // Counts only while the button stays down; a REL_WAIT->HELD bounce keeps
    // the count, and saturation guarantees a single pulse per hold.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (state_q == PRESS_WAIT && state_d == HELD) begin
            lcnt_d = '0;
        end else if (level && level_d && lcnt_q != LW'(LONG_CYC)) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_q == LW'(LONG_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Input-side conditioner for the active-low board push-buttons. Every button
// pin is synchronised and debounced independently; downstream logic uses only
// these outputs. Define BTN_LONG_PRESS_EN to add the btn_long output.
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_n        raw pins, active-low (0 = pressed), asynchronous to clk
//   btn_level    debounced state, 1 = pressed
//   btn_press    1-cycle pulse on accepted press
//   btn_release  1-cycle pulse on accepted release
//   btn_long     1-cycle long-press pulse (BTN_LONG_PRESS_EN only)
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned N_BTN       = 2,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic [N_BTN-1:0] btn_long
`endif
);

    localparam int unsigned D        = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

    // A one-cycle window would make the counter compare against zero.
    if (D < 2) begin : g_bad_debounce
        $error("btn_debounce: debounce window must be at least 2 cycles");
    end

    // Validated in every build so enabling the long-press option never turns
    // a legal parameter set into an illegal one.
    if (LONG_CYC < 1) begin : g_bad_long
        $error("btn_debounce: long-press time must be at least 1 cycle");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
`ifdef BTN_LONG_PRESS_EN
        btn_debounce_ch #(
            .D        (D),
            .LONG_CYC (LONG_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_n      (btn_n[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .rel        (btn_release[i]),
            .long_press (btn_long[i])
        );
`else
        btn_debounce_ch #(
            .D (D)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus randomised bouncing inputs,
// checked against a run-length model (a level flips after D consecutive
// opposite samples seen two clocks after the pin).
module tb_btn_debounce;

    localparam int unsigned CLK_HZ      = 1000;
    localparam int unsigned DEBOUNCE_MS = 4;
    localparam int unsigned N_BTN       = 2;
    localparam int unsigned LONG_MS     = 10;
    localparam int          D           = 4;
    localparam int          LONG_CYC    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
`ifdef BTN_LONG_PRESS_EN
    logic [N_BTN-1:0] btn_long;
`endif

    btn_debounce #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .N_BTN       (N_BTN),
        .LONG_MS     (LONG_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
`ifdef BTN_LONG_PRESS_EN
        ,
        .btn_long    (btn_long)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [N_BTN-1:0] h1, h2;
    logic [N_BTN-1:0] m_level, m_press, m_release, m_long;
    int               run  [N_BTN];
    int               held [N_BTN];

    // Advance one clock: update the model with the inputs the DUT samples at
    // this rising edge, then return at the falling edge for checking.
    task automatic tick();
        logic [N_BTN-1:0] seen;
        @(posedge clk);
        cyc++;
        if (rst) begin
            h1 = '1; h2 = '1;
            m_level = '0; m_press = '0; m_release = '0; m_long = '0;
            for (int i = 0; i < N_BTN; i++) begin
                run[i] = 0; held[i] = 0;
            end
        end else begin
            seen = h2;
            h2   = h1;
            h1   = btn_n;
            for (int i = 0; i < N_BTN; i++) begin
                m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
                if ((~seen[i]) != m_level[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == D) begin
                    run[i]     = 0;
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        held[i]    = 0;
                    end else begin
                        m_release[i] = 1'b1;
                    end
                end else if (m_level[i] && held[i] < LONG_CYC) begin
                    held[i]++;
                    if (held[i] == LONG_CYC) m_long[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_n = '1;
        repeat (3) tick();
        checks++;
        if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {btn_level, btn_press, btn_release});
        end
        rst = 1'b0;
        repeat (D + 3) tick();
        checks++;
        if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000000",
                     {btn_level, btn_press, btn_release});
        end
    endtask

    task automatic test_clean_press();
        int e0, np, pe, le;
        np = 0; pe = -1; le = -1;
        btn_n[0] = 1'b0;
        e0 = cyc + 1;
        repeat (10) begin
            tick();
            if (btn_press[0]) begin np++; pe = cyc; end
            if (btn_level[0] && le < 0) le = cyc;
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
                errors++;
                $display("FAIL press_model cyc %0d: got %b want %b", cyc,
                         {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
            end
            checks++;
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
                errors++;
                $display("FAIL press_ch1_quiet cyc %0d: got lvl %b prs %b want 0 0", cyc,
                         btn_level[1], btn_press[1]);
            end
        end
        checks++;
        if (np != 1 || pe != e0 + D + 1) begin
            errors++;
            $display("FAIL press_timing: got %0d pulses at edge %0d want 1 at edge %0d",
                     np, pe, e0 + D + 1);
        end
        checks++;
        if (le != pe || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_level: got rise edge %0d level %b want edge %0d level 1",
                     le, btn_level[0], pe);
        end
    endtask

    task automatic test_release();
        int e0, nr, re, fe, np;
        nr = 0; re = -1; fe = -1; np = 0;
        btn_n[0] = 1'b1;
        e0 = cyc + 1;
        repeat (10) begin
            tick();
            if (btn_release[0]) begin nr++; re = cyc; end
            if (btn_press[0]) np++;
            if (!btn_level[0] && fe < 0) fe = cyc;
        end
        checks++;
        if (nr != 1 || re != e0 + D + 1 || np != 0) begin
            errors++;
            $display("FAIL release_timing: got %0d rel at edge %0d (%0d press) want 1 at %0d",
                     nr, re, np, e0 + D + 1);
        end
        checks++;
        if (fe != re) begin
            errors++;
            $display("FAIL release_level: got fall edge %0d want %0d", fe, re);
        end
    endtask

    task automatic test_bounce();
        int ef, np, pe;
        np = 0; pe = -1;
        btn_n[0] = 1'b0; tick(); if (btn_press[0]) np++;
        tick(); if (btn_press[0]) np++;
        btn_n[0] = 1'b1; tick(); if (btn_press[0]) np++;
        btn_n[0] = 1'b0;
        ef = cyc + 1;
        repeat (10) begin
            tick();
            if (btn_press[0]) begin np++; pe = cyc; end
        end
        checks++;
        if (np != 1 || pe != ef + D + 1) begin
            errors++;
            $display("FAIL bounce_press: got %0d pulses at edge %0d want 1 at edge %0d",
                     np, pe, ef + D + 1);
        end
        test_release();
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        btn_n[1] = 1'b0;
        repeat (3) begin
            tick();
            if (btn_press[1] || btn_release[1] || btn_level[1]) bad++;
        end
        btn_n[1] = 1'b1;
        repeat (10) begin
            tick();
            if (btn_press[1] || btn_release[1] || btn_level[1]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_ignored: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int e0, np, pe, bad;
        np = 0; pe = -1; bad = 0;
        btn_n[0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            if (btn_press != '0 || btn_release != '0 || btn_level != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad);
        end
        rst = 1'b0;
        e0 = cyc + 1;
        repeat (10) begin
            tick();
            if (btn_press[0]) begin np++; pe = cyc; end
        end
        checks++;
        if (np != 1 || pe != e0 + D + 1) begin
            errors++;
            $display("FAIL reset_mid_press: got %0d pulses at edge %0d want 1 at edge %0d",
                     np, pe, e0 + D + 1);
        end
        test_release();
    endtask

`ifdef BTN_LONG_PRESS_EN
    task automatic test_long();
        int np, pe, nl, lg;
        np = 0; pe = -1; nl = 0; lg = -1;
        btn_n[0] = 1'b0;
        repeat (30) begin
            tick();
            if (btn_press[0]) begin np++; pe = cyc; end
            if (btn_long[0]) begin nl++; lg = cyc; end
        end
        checks++;
        if (np != 1 || nl != 1 || lg != pe + LONG_CYC) begin
            errors++;
            $display("FAIL long_press: got %0d long at edge %0d want 1 at edge %0d",
                     nl, lg, pe + LONG_CYC);
        end
        test_release();
    endtask
`endif

    task automatic test_random();
        int hold [N_BTN];
        int bad_model, bad_both;
        bad_model = 0; bad_both = 0;
        for (int i = 0; i < N_BTN; i++) hold[i] = 0;
        repeat (600) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (hold[i] == 0) begin
                    btn_n[i] = 1'($urandom_range(0, 1));
                    hold[i]  = int'($urandom_range(1, 8));
                end
                hold[i]--;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
                bad_model++;
                errors++;
                $display("FAIL random_model cyc %0d: got %b want %b", cyc,
                         {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
            end
`ifdef BTN_LONG_PRESS_EN
            checks++;
            if (btn_long !== m_long) begin
                errors++;
                $display("FAIL random_long cyc %0d: got %b want %b", cyc, btn_long, m_long);
            end
`endif
            if ((btn_press & btn_release) != '0) bad_both++;
        end
        rst = 1'b0;
        checks++;
        if (bad_both != 0) begin
            errors++;
            $display("FAIL press_release_exclusive: got %0d overlaps want 0", bad_both);
        end
        btn_n = '1;
        repeat (12) tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_n = '1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_mid();
`ifdef BTN_LONG_PRESS_EN
        test_long();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
